mem_port_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer for the shared single-port byte RAM (negedge-clocked, 8-bit address, 8-bit data, one access per cycle).
- Port 0 is the processor-side memory interface; port 1 is the loader/debug port.
- Drives the RAM's en/memwrite/adr/writedata.
- Captures its read data and returns it to the winning port with an ack pulse.
- Fully pipelined: one grant per cycle, ack two cycles after grant.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-port round-robin arbiter and sequencer for a shared
//                single-port byte RAM. Grants one access per cycle. Each
//                access is registered onto the RAM bus one cycle later, and
//                its read data is returned with an ack two cycles after grant.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WIDTH         = 8,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     p0_req,
    input  logic                     p0_we,
    input  logic [RAM_ADDR_BITS-1:0] p0_adr,
    input  logic [WIDTH-1:0]         p0_wdata,
    output logic                     p0_gnt,
    output logic                     p0_ack,

    input  logic                     p1_req,
    input  logic                     p1_we,
    input  logic [RAM_ADDR_BITS-1:0] p1_adr,
    input  logic [WIDTH-1:0]         p1_wdata,
    output logic                     p1_gnt,
    output logic                     p1_ack,

    output logic [WIDTH-1:0]         rdata,

    output logic                     mem_en,
    output logic                     mem_memwrite,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_writedata,
    input  logic [WIDTH-1:0]         mem_memdata
);

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    // Priority pointer: names the port that wins when both request.
    logic                     ptr_q,        ptr_d;

    // Issue stage: access currently presented to the RAM.
    logic                     mem_en_q,     mem_en_d;
    logic                     memwrite_q,   memwrite_d;
    logic [RAM_ADDR_BITS-1:0] adr_q,        adr_d;
    logic [WIDTH-1:0]         wdata_q,      wdata_d;
    logic                     iss_valid_q,  iss_valid_d;
    logic                     iss_port_q,   iss_port_d;

    // Response stage: captured read data and per-port completion pulses.
    logic [WIDTH-1:0]         rdata_q,      rdata_d;
    logic                     ack0_q,       ack0_d;
    logic                     ack1_q,       ack1_d;

    logic                     w_gnt0;
    logic                     w_gnt1;
    logic                     w_grant_any;

    // Grant decision: a lone requester wins, a tie goes to the pointer's port.
    // Only the req inputs steer the decision so an undriven idle port's other
    // inputs cannot leak into the grant.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                if (ptr_q == c_PORT1) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else if (p0_req) begin
                w_gnt0 = 1'b1;
            end else if (p1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_grant_any = w_gnt0 | w_gnt1;

    // Next-state for pointer, issue stage and response stage.
    always_comb begin
        ptr_d       = ptr_q;
        mem_en_d    = w_grant_any;
        memwrite_d  = 1'b0;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        iss_valid_d = w_grant_any;
        iss_port_d  = iss_port_q;

        // The winner's request moves into the issue stage and the pointer
        // passes to the other port so a persistent pair alternates.
        if (w_gnt0) begin
            memwrite_d = p0_we;
            adr_d      = p0_adr;
            wdata_d    = p0_wdata;
            iss_port_d = c_PORT0;
            ptr_d      = c_PORT1;
        end else if (w_gnt1) begin
            memwrite_d = p1_we;
            adr_d      = p1_adr;
            wdata_d    = p1_wdata;
            iss_port_d = c_PORT1;
            ptr_d      = c_PORT0;
        end

        // The RAM answered at the negedge inside the issue cycle; capture it
        // and signal completion to whichever port owned that access.
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        if (iss_valid_q) begin
            rdata_d = mem_memdata;
            ack0_d  = (iss_port_q == c_PORT0);
            ack1_d  = (iss_port_q == c_PORT1);
        end
    end

    // State registers; reset discards any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= c_PORT0;
            mem_en_q    <= 1'b0;
            memwrite_q  <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_port_q  <= c_PORT0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            mem_en_q    <= mem_en_d;
            memwrite_q  <= memwrite_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            iss_valid_q <= iss_valid_d;
            iss_port_q  <= iss_port_d;
            rdata_q     <= rdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign p0_gnt        = w_gnt0;
    assign p1_gnt        = w_gnt1;
    assign p0_ack        = ack0_q;
    assign p1_ack        = ack1_q;
    assign rdata         = rdata_q;
    assign mem_en        = mem_en_q;
    assign mem_memwrite  = memwrite_q;
    assign mem_adr       = adr_q;
    assign mem_writedata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a negedge RAM,
//                a transaction-level reference model and an ack scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic       clk;
    logic       reset;
    logic       p0_req, p0_we, p0_gnt, p0_ack;
    logic [7:0] p0_adr, p0_wdata;
    logic       p1_req, p1_we, p1_gnt, p1_ack;
    logic [7:0] p1_adr, p1_wdata;
    logic [7:0] rdata;
    logic       mem_en, mem_memwrite;
    logic [7:0] mem_adr, mem_writedata, mem_memdata;

    mem_port_arbiter #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack),
        .rdata(rdata),
        .mem_en(mem_en), .mem_memwrite(mem_memwrite), .mem_adr(mem_adr),
        .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // RAM: negedge clocked, read-before-write.
    logic [7:0] ram    [256];
    logic [7:0] shadow [256];
    always @(negedge clk) begin
        if (mem_en) begin
            mem_memdata <= ram[mem_adr];
            if (mem_memwrite) ram[mem_adr] <= mem_writedata;
        end
    end

    typedef struct {
        bit       port;
        logic [7:0] data;
        int       cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: transaction level.
    bit         last_winner = 1'b1;   // tie goes to the port that did not win last
    bit         mg0 = 0, mg1 = 0;     // model grants this cycle (used by the driver)
    bit         iss_v = 0;
    bit         iss_we = 0;
    logic [7:0] iss_adr = 0, iss_wd = 0;
    logic [7:0] last_rdata = 0;

    // Grant and issue-stage checker; pushes expected responses.
    always @(negedge clk) begin
        bit eg0, eg1;
        eg0 = 0; eg1 = 0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                eg0 = (last_winner == 1'b1);
                eg1 = !eg0;
            end else begin
                eg0 = p0_req;
                eg1 = p1_req;
            end
        end
        chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, eg1, eg0});
        chk("mem_en", {31'd0, mem_en}, {31'd0, iss_v});
        if (iss_v) begin
            chk("mem_memwrite", {31'd0, mem_memwrite}, {31'd0, iss_we});
            chk("mem_adr", {24'd0, mem_adr}, {24'd0, iss_adr});
            chk("mem_writedata", {24'd0, mem_writedata}, {24'd0, iss_wd});
        end else begin
            chk("mem_memwrite_idle", {31'd0, mem_memwrite}, 32'd0);
        end
        iss_v = eg0 | eg1;
        if (reset) begin
            last_winner = 1'b1;
        end else if (eg0 || eg1) begin
            exp_t e;
            e.port  = eg1;
            iss_we  = eg1 ? p1_we : p0_we;
            iss_adr = eg1 ? p1_adr : p0_adr;
            iss_wd  = eg1 ? p1_wdata : p0_wdata;
            e.data  = shadow[iss_adr];
            e.cyc   = cyc + 2;
            exp_q.push_back(e);
            if (iss_we) shadow[iss_adr] = iss_wd;
            last_winner = eg1;
        end
        mg0 = eg0;
        mg1 = eg1;
    end

    // Ack monitor: pops the scoreboard whenever the DUT presents an ack.
    always @(negedge clk) begin
        if (p0_ack || p1_ack) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_port", {30'd0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
                chk("ack_rdata", {24'd0, rdata}, {24'd0, e.data});
                chk("ack_cycle", e.cyc, cyc);
                last_rdata = e.data;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_missing", {30'd0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
        end
        if (reset) begin
            exp_q.delete();
            last_rdata = 0;
        end
    end

    task automatic drv(input logic rst,
                       input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        @(posedge clk);
        #1;
        reset = rst;
        p0_req = r0; p0_we = w0; p0_adr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_adr = a1; p1_wdata = d1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'(i) ^ 8'hC3;
            shadow[i] = 8'(i) ^ 8'hC3;
        end
        ram[8'h10] = 8'h5A; shadow[8'h10] = 8'h5A;
        ram[8'h01] = 8'h11; shadow[8'h01] = 8'h11;
        ram[8'h02] = 8'h22; shadow[8'h02] = 8'h22;
        ram[8'h33] = 8'h00; shadow[8'h33] = 8'h00;
        mem_memdata = 0;
        reset = 1;
        p0_req = 0; p0_we = 0; p0_adr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_adr = 0; p1_wdata = 0;
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_mem_adr", {24'd0, mem_adr}, 32'd0);

        // Single read.
        drv(0, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        idle(3);
        // Write then read-back on port 1.
        drv(0, 0, 0, 0, 0, 1, 1, 8'h33, 8'hA7);
        drv(0, 0, 0, 0, 0, 1, 0, 8'h33, 0);
        idle(3);
        // Contention.
        for (int i = 0; i < 6; i++) drv(0, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        idle(3);
        // Single-port streaming.
        for (int i = 0; i < 8; i++) drv(0, 1, 0, 8'(i), 0, 0, 0, 0, 0);
        idle(3);

        // Reset mid-burst; pointer was left at port 1 by the stream.
        for (int i = 0; i < 4; i++) drv(0, 1, 0, 8'(8'h20 + i), 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("midrst_memwrite", {31'd0, mem_memwrite}, 32'd0);
        chk("midrst_mem_adr", {24'd0, mem_adr}, 32'd0);
        chk("midrst_wdata", {24'd0, mem_writedata}, 32'd0);
        chk("midrst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("midrst_rdata", {24'd0, rdata}, 32'd0);
        drv(0, 1, 0, 8'h10, 0, 1, 0, 8'h01, 0);
        idle(4);

        // Idle.
        idle(20);
        @(negedge clk);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle_memwrite", {31'd0, mem_memwrite}, 32'd0);
        chk("idle_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        chk("idle_rdata", {24'd0, rdata}, {24'd0, last_rdata});

        // Randomized traffic; a request is held until the model grants it.
        for (int i = 0; i < 400; i++) begin
            logic       r0, w0, r1, w1, rs;
            logic [7:0] a0, d0, a1, d1;
            rs = ($urandom_range(0, 59) == 0);
            if (p0_req && !mg0) begin
                r0 = p0_req; w0 = p0_we; a0 = p0_adr; d0 = p0_wdata;
            end else begin
                r0 = ($urandom_range(0, 3) != 0); w0 = 1'($urandom);
                a0 = 8'($urandom_range(0, 15)); d0 = 8'($urandom);
            end
            if (p1_req && !mg1) begin
                r1 = p1_req; w1 = p1_we; a1 = p1_adr; d1 = p1_wdata;
            end else begin
                r1 = ($urandom_range(0, 2) == 0); w1 = 1'($urandom);
                a1 = 8'($urandom_range(0, 15)); d1 = 8'($urandom);
            end
            drv(rs, r0, w0, a0, d0, r1, w1, a1, d1);
        end
        idle(5);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
